pipe_stage_elastic: RTL and testbench

Parametrised elastic pipeline register with a valid/ready handshake on both sides. It generalises the fixed pause/bubble stage registers to any payload width. Back-pressure replaces the global pause, and a synchronous flush replaces bubble. It sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB), carrying each stage's packed payload.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_slot.sv | 31 +++
 rtl/pipe_stage_elastic.sv | 147 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the elastic pipeline stage: FSM state codes (equal to
// occupancy) and the RISC-V NOP used as the IF/ID bubble payload.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_slot.sv
// Single payload register of the elastic stage: load, clear-to-BUBBLE,
// asynchronous active-low reset to BUBBLE. Clear wins over load.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_reg <= BUBBLE;
      end else if (clear) begin
         data_reg <= BUBBLE;
      end else if (load) begin
         data_reg <= d;
      end
   end

   assign q = data_reg;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with flush. Define PIPE_STAGE_SKID_EN
// for the two-slot (skid) variant with a registered in_ready.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
   parameter int               BYPASS = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   generate
      if (BYPASS != 0) begin : g_bypass
         assign out_valid = in_valid & ~flush;
         assign in_ready  = out_ready;
         assign out_data  = out_valid ? in_data : BUBBLE;
         assign occupancy = 2'd0;
      end else begin : g_reg
         state_t           state_reg, state_next;
         logic             accept, fire;
         logic             main_load, main_clear;
         logic [WIDTH-1:0] main_d, main_q;
`ifdef PIPE_STAGE_SKID_EN
         logic             skid_load, skid_clear;
         logic [WIDTH-1:0] skid_q;
         logic             ready_reg;
`endif

         assign out_valid = (state_reg != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
         assign in_ready  = ready_reg;
`else
         assign in_ready  = ~out_valid | out_ready;
`endif
         assign accept    = in_valid & in_ready;
         assign fire      = out_valid & out_ready;
         // main is reloaded with BUBBLE whenever it goes empty, so it is the output
         assign out_data  = main_q;
         assign occupancy = state_reg;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               state_reg <= ST_EMPTY;
            end else begin
               state_reg <= state_next;
            end
         end

`ifdef PIPE_STAGE_SKID_EN
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               ready_reg <= 1'b1;
            end else begin
               ready_reg <= (state_next != ST_TWO);
            end
         end
`endif

         always_comb begin
            state_next = state_reg;
            main_load  = 1'b0;
            main_clear = 1'b0;
            main_d     = in_data;
`ifdef PIPE_STAGE_SKID_EN
            skid_load  = 1'b0;
            skid_clear = 1'b0;
`endif
            case (state_reg)
               ST_EMPTY: begin
                  if (accept) begin
                     main_load  = 1'b1;
                     state_next = ST_ONE;
                  end
               end
               ST_ONE: begin
                  if (accept && fire) begin
                     main_load = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                  end else if (accept) begin
                     skid_load  = 1'b1;
                     state_next = ST_TWO;
`endif
                  end else if (fire) begin
                     main_clear = 1'b1;
                     state_next = ST_EMPTY;
                  end
               end
`ifdef PIPE_STAGE_SKID_EN
               ST_TWO: begin
                  if (fire) begin
                     main_d     = skid_q;
                     main_load  = 1'b1;
                     skid_clear = 1'b1;
                     state_next = ST_ONE;
                  end
               end
`endif
               default: begin
                  main_clear = 1'b1;
                  state_next = ST_EMPTY;
               end
            endcase
            // flush overrides everything; a same-cycle fire is already delivered
            if (flush) begin
               state_next = ST_EMPTY;
               main_load  = 1'b0;
               main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
               skid_load  = 1'b0;
               skid_clear = 1'b1;
`endif
            end
         end

         pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_main (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (main_load),
            .clear   (main_clear),
            .d       (main_d),
            .q       (main_q)
         );

`ifdef PIPE_STAGE_SKID_EN
         pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_skid (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (skid_load),
            .clear   (skid_clear),
            .d       (in_data),
            .q       (skid_q)
         );
`endif
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic with a queue scoreboard on the output
// handshake, plus a BYPASS=1 WIDTH=8 instance.
module tb_pipe_stage_elastic;
   import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
   localparam int SKID = 1;
`else
   localparam int SKID = 0;
`endif
   localparam logic [7:0] B_BUBBLE = 8'h5A;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] in_data, out_data;
   logic [1:0]  occupancy;

   logic        b_flush, b_in_valid, b_out_ready;
   logic        b_in_ready, b_out_valid;
   logic [7:0]  b_in_data, b_out_data;
   logic [1:0]  b_occupancy;

   int          checks = 0;
   int          errors = 0;
   int          fires  = 0;
   logic [31:0] exp_q[$];

   always #5 clock = ~clock;

   pipe_stage_elastic #(.WIDTH(32), .BUBBLE(RV_NOP), .BYPASS(0)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   pipe_stage_elastic #(.WIDTH(8), .BUBBLE(B_BUBBLE), .BYPASS(1)) dut_bypass (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (b_flush),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .occupancy (b_occupancy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard: handshakes sampled mid-cycle, where inputs and outputs are stable.
   always @(negedge clock) begin
      logic [31:0] ex;
      if (!reset_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            fires++;
            ex = (exp_q.size() > 0) ? exp_q.pop_front() : (out_data ^ 32'hDEAD_BEEF);
            check("sb_data", out_data, ex);
            $display("OUT data=%h occupancy=%0d", out_data, occupancy);
         end
         if (flush) exp_q.delete();
         else if (in_valid && in_ready) exp_q.push_back(in_data);
      end
   end

   initial begin
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
      repeat (2) step();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, RV_NOP);
      check("rst_occupancy", {30'd0, occupancy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      reset_n = 1'b1;
      step();

      // reset in the middle of a filled stage
      in_valid = 1'b1; in_data = 32'h100;
      step();
      in_data = 32'h101;
      step();
      in_valid = 1'b0;
      check("fill_occupancy", {30'd0, occupancy}, (SKID != 0) ? 32'd2 : 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_out_data", out_data, RV_NOP);
      check("async_occupancy", {30'd0, occupancy}, 32'd0);
      step();
      reset_n = 1'b1;
      in_valid = 1'b1; in_data = 32'hA5;
      step();
      in_valid = 1'b0;
      check("a5_out_valid", {31'd0, out_valid}, 32'd1);
      check("a5_out_data", out_data, 32'hA5);
      out_ready = 1'b1;
      step();
      check("a5_drained", {30'd0, occupancy}, 32'd0);
      check("a5_bubble", out_data, RV_NOP);

      // streaming at one transfer per cycle
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1; in_data = i;
         step();
         check("stream_data", out_data, i);
         check("stream_occupancy", {30'd0, occupancy}, 32'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drained", {31'd0, out_valid}, 32'd0);

      // back-pressure
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h11;
      step();
      check("bp_in_ready_1", {31'd0, in_ready}, 32'd0 + ((SKID != 0) ? 32'd1 : 32'd0));
      in_data = 32'h22;
      step();
      check("bp_occupancy", {30'd0, occupancy}, (SKID != 0) ? 32'd2 : 32'd1);
      check("bp_in_ready_2", {31'd0, in_ready}, 32'd0);
      check("bp_head", out_data, 32'h11);
`ifdef PIPE_STAGE_SKID_EN
      in_data = 32'h33;
      step();
      check("bp_hold_occupancy", {30'd0, occupancy}, 32'd2);
      out_ready = 1'b1;
      step();
      check("bp_out_22", out_data, 32'h22);
      check("bp_in_ready_3", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_out_33", out_data, 32'h33);
      step();
`else
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_comb", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_out_22", out_data, 32'h22);
      check("bp_occ_max1", {30'd0, occupancy}, 32'd1);
      step();
`endif
      check("bp_drained", {30'd0, occupancy}, 32'd0);

      // flush of a full stage, incoming word discarded
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h44;
      step();
      in_data = 32'h55;
      step();
      flush = 1'b1; in_data = 32'h66;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_occupancy", {30'd0, occupancy}, 32'd0);
      check("flush_bubble", out_data, RV_NOP);
      step();
      check("flush_no_66", {31'd0, out_valid}, 32'd0);

      // flush with one entry: fire delivered, accept discarded, in_ready ungated
      in_valid = 1'b1; in_data = 32'h77;
      step();
      out_ready = 1'b1; flush = 1'b1; in_data = 32'h88;
      #1;
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush2_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush2_bubble", out_data, RV_NOP);
      step();
      check("flush2_no_88", {31'd0, out_valid}, 32'd0);

      check("sb_leftover", exp_q.size(), 32'd0);
      check("sb_fire_count", fires, (SKID != 0) ? 32'd21 : 32'd20);

      // combinational bypass instance
      b_in_valid = 1'b1; b_in_data = 8'h3C; b_out_ready = 1'b0;
      #1;
      check("byp_out_valid", {31'd0, b_out_valid}, 32'd1);
      check("byp_out_data", {24'd0, b_out_data}, 32'h3C);
      check("byp_in_ready_0", {31'd0, b_in_ready}, 32'd0);
      check("byp_occupancy", {30'd0, b_occupancy}, 32'd0);
      b_out_ready = 1'b1;
      #1;
      check("byp_in_ready_1", {31'd0, b_in_ready}, 32'd1);
      b_flush = 1'b1;
      #1;
      check("byp_flush_valid", {31'd0, b_out_valid}, 32'd0);
      check("byp_flush_data", {24'd0, b_out_data}, {24'd0, B_BUBBLE});
      b_flush = 1'b0; b_in_valid = 1'b0;
      #1;
      check("byp_idle_data", {24'd0, b_out_data}, {24'd0, B_BUBBLE});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
